// File: rtl/patgen_pkg.sv
// Shared types and constants for the timing/pattern generator: pattern
// encoding, colour-bar table and component scaling for arbitrary DATA_W.
package patgen_pkg;

    typedef enum logic [1:0] {
        PT_BARS  = 2'd0,
        PT_RAMP  = 2'd1,
        PT_SOLID = 2'd2,
        PT_CHECK = 2'd3
    } pattern_e;

    localparam int MAX_BARS = 8;

    // 8-bit-per-component reference colours: R, G, B, W, Y, C, M, K
    localparam logic [23:0] BAR_COLORS [MAX_BARS] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
        24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000
    };

    // Stretch an 8-bit component to comp_w bits by repeating its bit pattern
    // MSB-first; narrower widths keep the top bits. Caller truncates the result.
    function automatic logic [31:0] scale_comp(input logic [7:0] c8, input int comp_w);
        logic [31:0] res;
        logic [7:0]  rot;
        res = '0;
        rot = c8;
        for (int i = 0; i < 32; i++) begin
            if (i < comp_w) begin
                res = {res[30:0], rot[7]};
                rot = {rot[6:0], rot[7]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus stability counter; emits a single-clock pulse
// once the key has been high for more than DEBOUNCE_CYC consecutive clocks.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 20000
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_in,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 2);
    localparam logic [CW-1:0] CNT_HIT = CW'(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_SAT = CW'(DEBOUNCE_CYC + 1);

    logic          key_meta_reg;
    logic          key_sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          press_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_meta_reg <= 1'b0;
            key_sync_reg <= 1'b0;
            cnt_reg      <= '0;
            press_reg    <= 1'b0;
        end else begin
            key_meta_reg <= key_in;
            key_sync_reg <= key_meta_reg;
            // Counter saturates so a held key produces exactly one pulse
            if (!key_sync_reg)
                cnt_reg <= '0;
            else if (cnt_reg != CNT_SAT)
                cnt_reg <= cnt_reg + 1'b1;
            press_reg <= key_sync_reg && (cnt_reg == CNT_HIT);
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/timing_pattern_gen.sv
// Video timing generator with four selectable test patterns, switched only at
// frame start. Define PATGEN_SCROLL_EN to scroll bars/checker 1 px per frame.
module timing_pattern_gen
    import patgen_pkg::*;
#(
    parameter int H_TOTAL      = 1252,
    parameter int H_VAL        = 1242,
    parameter int HFP          = 4,
    parameter int HSP          = 6,
    parameter int HBP          = 0,
    parameter int V_TOTAL      = 2706,
    parameter int V_VAL        = 1920,
    parameter int VFP          = 10,
    parameter int VSP          = 3,
    parameter int VBP          = 5,
    parameter int DATA_W       = 24,
    parameter int NUM_BARS     = 8,
    parameter int CHK_LOG2     = 5,
    parameter int DEBOUNCE_CYC = 20000,
    parameter logic [DATA_W-1:0] SOLID_COLOR = DATA_W'(24'h0000FF)
) (
    input  logic              px_clk,
    input  logic              rstn,
    input  logic [3:0]        key,
    output logic              hsync,
    output logic              vsync,
    output logic              dval,
    output logic              line_en,
    output logic              frame_start,
    output logic [DATA_W-1:0] px_data,
    output logic [1:0]        pt_sel
);

    localparam int COMP_W = DATA_W / 3;
    localparam int BAR_W  = H_VAL / NUM_BARS;
    localparam int HW     = $clog2(H_TOTAL + 1);
    localparam int VW     = $clog2(V_TOTAL + 1);
    localparam int BW     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int PW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HS_START = HW'(HFP);
    localparam logic [HW-1:0] HS_END   = HW'(HFP + HSP);
    localparam logic [HW-1:0] HA_START = HW'(HFP + HSP + HBP);
    localparam logic [HW-1:0] HA_END   = HW'(HFP + HSP + HBP + H_VAL);
    localparam logic [HW-1:0] X_LAST   = HW'(H_VAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] VS_START = VW'(VFP);
    localparam logic [VW-1:0] VS_END   = VW'(VFP + VSP);
    localparam logic [VW-1:0] VA_START = VW'(VFP + VSP + VBP);
    localparam logic [VW-1:0] VA_END   = VW'(VFP + VSP + VBP + V_VAL);
    localparam logic [BW-1:0] BAR_LAST = BW'(NUM_BARS - 1);
    localparam logic [PW-1:0] PX_LAST  = PW'(BAR_W - 1);
    localparam logic [HW-1:0] CHK_X_MASK = HW'(1 << CHK_LOG2);
    localparam logic [VW-1:0] CHK_Y_MASK = VW'(1 << CHK_LOG2);

    generate
        if (HFP + HSP + HBP + H_VAL > H_TOTAL) begin : g_h_illegal
            $error("timing_pattern_gen: horizontal fields exceed H_TOTAL");
        end
        if (VFP + VSP + VBP + V_VAL > V_TOTAL) begin : g_v_illegal
            $error("timing_pattern_gen: vertical fields exceed V_TOTAL");
        end
        if ((DATA_W % 3) != 0 || COMP_W > 32) begin : g_w_illegal
            $error("timing_pattern_gen: DATA_W must be a multiple of 3, max 96");
        end
        if (NUM_BARS < 1 || NUM_BARS > MAX_BARS || BAR_W < 1) begin : g_bar_illegal
            $error("timing_pattern_gen: NUM_BARS out of range for H_VAL");
        end
    endgenerate

    // One step of the running bar position (x', bar index, px within bar);
    // replaces a divide by BAR_W. x' wraps at H_VAL back to bar 0.
    function automatic void bar_step(
        input  logic [HW-1:0] xs_i, input  logic [BW-1:0] bar_i, input  logic [PW-1:0] px_i,
        output logic [HW-1:0] xs_o, output logic [BW-1:0] bar_o, output logic [PW-1:0] px_o
    );
        xs_o  = xs_i + 1'b1;
        bar_o = bar_i;
        px_o  = px_i + 1'b1;
        if (xs_i == X_LAST) begin
            xs_o  = '0;
            bar_o = '0;
            px_o  = '0;
        end else if (bar_i == BAR_LAST) begin
            px_o = px_i;
        end else if (px_i == PX_LAST) begin
            bar_o = bar_i + 1'b1;
            px_o  = '0;
        end
    endfunction

    logic [HW-1:0]     hcnt_reg, hcnt_next;
    logic [VW-1:0]     vcnt_reg, vcnt_next;
    logic              h_wrap, frame_tick, hs_win, vs_win, h_act, v_act;
    logic [HW-1:0]     xs_reg, xs_next, xs_adv, start_xs;
    logic [BW-1:0]     bar_reg, bar_next, bar_adv, start_bar;
    logic [PW-1:0]     bpx_reg, bpx_next, bpx_adv, start_bpx;
    logic [1:0]        pend_sel_reg, pt_sel_reg;
    pattern_e          sel_eff;
    logic              key_press;
    logic              unused_key;
    logic [23:0]       bar_color;
    logic [COMP_W-1:0] ramp_comp;
    logic              chk_bit;
    logic [DATA_W-1:0] bar_pix, ramp_pix, pix;
    logic              hsync_reg, vsync_reg, dval_reg, line_en_reg, frame_start_reg;
    logic [DATA_W-1:0] px_data_reg;

    assign h_wrap     = (hcnt_reg == H_LAST);
    assign hcnt_next  = h_wrap ? '0 : hcnt_reg + 1'b1;
    assign vcnt_next  = !h_wrap ? vcnt_reg : ((vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1);
    assign frame_tick = (hcnt_reg == '0) && (vcnt_reg == '0);
    assign hs_win     = (hcnt_reg >= HS_START) && (hcnt_reg < HS_END);
    assign vs_win     = (vcnt_reg >= VS_START) && (vcnt_reg < VS_END);
    assign h_act      = (hcnt_reg >= HA_START) && (hcnt_reg < HA_END);
    assign v_act      = (vcnt_reg >= VA_START) && (vcnt_reg < VA_END);
    assign unused_key = ^key[3:1];

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_debounce (
        .clk    (px_clk),
        .rstn   (rstn),
        .key_in (key[0]),
        .press  (key_press)
    );

`ifdef PATGEN_SCROLL_EN
    logic [15:0]   fcnt_reg;
    logic [HW-1:0] off_xs_reg, off_xs_adv;
    logic [BW-1:0] off_bar_reg, off_bar_adv;
    logic [PW-1:0] off_bpx_reg, off_bpx_adv;

    // Line start position tracks fcnt mod H_VAL; it restarts when fcnt wraps
    always_comb begin
        bar_step(off_xs_reg, off_bar_reg, off_bpx_reg, off_xs_adv, off_bar_adv, off_bpx_adv);
        start_xs  = off_xs_reg;
        start_bar = off_bar_reg;
        start_bpx = off_bpx_reg;
        if (frame_tick) begin
            if (fcnt_reg == 16'hFFFF) begin
                start_xs  = '0;
                start_bar = '0;
                start_bpx = '0;
            end else begin
                start_xs  = off_xs_adv;
                start_bar = off_bar_adv;
                start_bpx = off_bpx_adv;
            end
        end
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            fcnt_reg    <= '0;
            off_xs_reg  <= '0;
            off_bar_reg <= '0;
            off_bpx_reg <= '0;
        end else begin
            if (frame_tick)
                fcnt_reg <= fcnt_reg + 1'b1;
            off_xs_reg  <= start_xs;
            off_bar_reg <= start_bar;
            off_bpx_reg <= start_bpx;
        end
    end
`else
    assign start_xs  = '0;
    assign start_bar = '0;
    assign start_bpx = '0;
`endif

    always_comb begin
        bar_step(xs_reg, bar_reg, bpx_reg, xs_adv, bar_adv, bpx_adv);
        xs_next  = xs_reg;
        bar_next = bar_reg;
        bpx_next = bpx_reg;
        if (hcnt_next == HA_START) begin
            xs_next  = start_xs;
            bar_next = start_bar;
            bpx_next = start_bpx;
        end else if (h_act) begin
            xs_next  = xs_adv;
            bar_next = bar_adv;
            bpx_next = bpx_adv;
        end
    end

    // Pixel at hcnt=vcnt=0 already belongs to the newly selected pattern
    assign sel_eff   = pattern_e'(frame_tick ? pend_sel_reg : pt_sel_reg);
    assign bar_color = BAR_COLORS[3'(bar_reg)];
    assign ramp_comp = COMP_W'(hcnt_reg - HA_START);
    assign chk_bit   = (|(xs_reg & CHK_X_MASK)) ^ (|((vcnt_reg - VA_START) & CHK_Y_MASK));

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_comp
            assign bar_pix[gi*COMP_W +: COMP_W]  = COMP_W'(scale_comp(bar_color[gi*8 +: 8], COMP_W));
            assign ramp_pix[gi*COMP_W +: COMP_W] = ramp_comp;
        end
    endgenerate

    always_comb begin
        pix = '0;
        case (sel_eff)
            PT_BARS:  pix = bar_pix;
            PT_RAMP:  pix = ramp_pix;
            PT_SOLID: pix = SOLID_COLOR;
            PT_CHECK: pix = chk_bit ? '1 : '0;
            default:  pix = '0;
        endcase
    end

    always_ff @(posedge px_clk) begin
        if (!rstn) begin
            hcnt_reg        <= '0;
            vcnt_reg        <= '0;
            xs_reg          <= '0;
            bar_reg         <= '0;
            bpx_reg         <= '0;
            pend_sel_reg    <= '0;
            pt_sel_reg      <= '0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            dval_reg        <= 1'b0;
            line_en_reg     <= 1'b0;
            frame_start_reg <= 1'b0;
            px_data_reg     <= '0;
        end else begin
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            xs_reg          <= xs_next;
            bar_reg         <= bar_next;
            bpx_reg         <= bpx_next;
            pend_sel_reg    <= pend_sel_reg + 2'(key_press);
            if (frame_tick)
                pt_sel_reg  <= pend_sel_reg;
            hsync_reg       <= hs_win;
            vsync_reg       <= vs_win;
            dval_reg        <= h_act && v_act;
            line_en_reg     <= v_act;
            frame_start_reg <= frame_tick;
            px_data_reg     <= (h_act && v_act) ? pix : '0;
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign dval        = dval_reg;
    assign line_en     = line_en_reg;
    assign frame_start = frame_start_reg;
    assign px_data     = px_data_reg;
    assign pt_sel      = pt_sel_reg;

endmodule

// File: tb/tb_timing_pattern_gen.sv
// Directed bench for timing_pattern_gen on a 20x10 frame: reset, timing windows,
// pattern contents, key debounce and frame-aligned pattern switching.
module tb_timing_pattern_gen;

    localparam int FRAME = 200;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  key;
    logic        hsync, vsync, dval, line_en, frame_start;
    logic [23:0] px_data;
    logic [1:0]  pt_sel;

    int checks   = 0;
    int failures = 0;

    typedef logic [23:0] line_t [8];

    line_t bars_exp = '{24'hFF0000, 24'hFF0000, 24'h00FF00, 24'h00FF00,
                        24'h0000FF, 24'h0000FF, 24'hFFFFFF, 24'hFFFFFF};
    line_t ramp_exp = '{24'h000000, 24'h010101, 24'h020202, 24'h030303,
                        24'h040404, 24'h050505, 24'h060606, 24'h070707};
    line_t solid_exp = '{24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF,
                         24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF};
    line_t chk_a_exp = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF,
                         24'h000000, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    line_t chk_b_exp = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000,
                         24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};

    logic        dv_a [FRAME];
    logic        hs_a [FRAME];
    logic        vs_a [FRAME];
    logic        le_a [FRAME];
    logic        fs_a [FRAME];
    logic [23:0] px_a [FRAME];
    logic [23:0] px_prev [FRAME];
    logic        fs_next;
    logic [1:0]  prev_sel;

    always #5 clk = ~clk;

    timing_pattern_gen #(
        .H_TOTAL(20), .H_VAL(8), .HFP(2), .HSP(2), .HBP(2),
        .V_TOTAL(10), .V_VAL(4), .VFP(1), .VSP(1), .VBP(1),
        .DATA_W(24), .NUM_BARS(4), .CHK_LOG2(1), .DEBOUNCE_CYC(4)
    ) dut (
        .px_clk      (clk),
        .rstn        (rstn),
        .key         (key),
        .hsync       (hsync),
        .vsync       (vsync),
        .dval        (dval),
        .line_en     (line_en),
        .frame_start (frame_start),
        .px_data     (px_data),
        .pt_sel      (pt_sel)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        repeat (n) tick();
    endtask

    task automatic press_key();
        key[0] = 1'b1;
        advance(10);
        key[0] = 1'b0;
        advance(10);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_hsync"},   32'(hsync),       32'd0);
        check_val({tag, "_vsync"},   32'(vsync),       32'd0);
        check_val({tag, "_dval"},    32'(dval),        32'd0);
        check_val({tag, "_line_en"}, 32'(line_en),     32'd0);
        check_val({tag, "_fstart"},  32'(frame_start), 32'd0);
        check_val({tag, "_px"},      32'(px_data),     32'd0);
        check_val({tag, "_pt_sel"},  32'(pt_sel),      32'd0);
    endtask

    // First clock after release shows hcnt=0; hsync window starts at hcnt=2
    task automatic release_check(input string tag);
        rstn = 1'b1;
        tick();
        check_val({tag, "_fs_first"}, 32'(frame_start), 32'd1);
        check_val({tag, "_hs_clk1"},  32'(hsync),       32'd0);
        tick();
        check_val({tag, "_hs_clk2"},  32'(hsync),       32'd0);
        tick();
        check_val({tag, "_hs_clk3"},  32'(hsync),       32'd1);
    endtask

    task automatic wait_fs(input string tag, output logic [1:0] sel_before);
        int n;
        n = 0;
        sel_before = pt_sel;
        while (frame_start !== 1'b1 && n < 250) begin
            sel_before = pt_sel;
            tick();
            n++;
        end
        check_val({tag, "_fs_seen"}, 32'(frame_start), 32'd1);
    endtask

    // Call with frame_start high; leaves the bench at the next frame's first clock
    task automatic capture_frame();
        for (int p = 0; p < FRAME; p++) begin
            if (p != 0) tick();
            dv_a[p] = dval;
            hs_a[p] = hsync;
            vs_a[p] = vsync;
            le_a[p] = line_en;
            fs_a[p] = frame_start;
            px_a[p] = px_data;
        end
        tick();
        fs_next = frame_start;
    endtask

    task automatic check_timing(input string tag);
        int dv_tot, hs_tot, vs_tot, le_tot, fs_tot, stray, first_dv, first_hs, line_cnt;
        dv_tot = 0; hs_tot = 0; vs_tot = 0; le_tot = 0; fs_tot = 0; stray = 0;
        first_dv = -1; first_hs = -1;
        for (int p = 0; p < FRAME; p++) begin
            dv_tot += int'(dv_a[p]);
            hs_tot += int'(hs_a[p]);
            vs_tot += int'(vs_a[p]);
            le_tot += int'(le_a[p]);
            fs_tot += int'(fs_a[p]);
            if (!dv_a[p] && px_a[p] != 24'h0) stray++;
            if (dv_a[p] && first_dv < 0) first_dv = p;
            if (hs_a[p] && first_hs < 0) first_hs = p;
        end
        check_val({tag, "_dval_total"},  32'(dv_tot),  32'd32);
        check_val({tag, "_hsync_total"}, 32'(hs_tot),  32'd20);
        check_val({tag, "_vsync_total"}, 32'(vs_tot),  32'd20);
        check_val({tag, "_line_en_tot"}, 32'(le_tot),  32'd80);
        check_val({tag, "_fs_count"},    32'(fs_tot),  32'd1);
        check_val({tag, "_fs_at_0"},     32'(fs_a[0]), 32'd1);
        check_val({tag, "_fs_period"},   32'(fs_next), 32'd1);
        check_val({tag, "_first_dval"},  32'(first_dv), 32'd66);
        check_val({tag, "_first_hsync"}, 32'(first_hs), 32'd2);
        check_val({tag, "_px_outside"},  32'(stray),   32'd0);
        for (int v = 0; v < 10; v++) begin
            line_cnt = 0;
            for (int h = 0; h < 20; h++) line_cnt += int'(dv_a[v*20 + h]);
            check_val($sformatf("%s_dval_line%0d", tag, v), 32'(line_cnt),
                      (v >= 3 && v <= 6) ? 32'd8 : 32'd0);
        end
    endtask

    // Active pixel (x,y) lands at frame position (y+3)*20 + 6 + x
    task automatic check_line(input string tag, input int y, input line_t exp);
        for (int x = 0; x < 8; x++)
            check_val($sformatf("%s_y%0d_x%0d", tag, y, x), 32'(px_a[(y+3)*20 + 6 + x]), 32'(exp[x]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mism;
        rstn = 1'b0;
        key  = 4'b0000;
        advance(3);
        check_zero("por");
        release_check("por_rel");

        // Unused keys held high must not affect the pattern
        key[3:1] = 3'b111;
        wait_fs("f1", prev_sel);
        capture_frame();
        check_timing("f1");
        check_val("f1_pt_sel", 32'(pt_sel), 32'd0);
`ifndef PATGEN_SCROLL_EN
        check_line("bars", 0, bars_exp);
        check_line("bars", 3, bars_exp);
`endif
        for (int p = 0; p < FRAME; p++) px_prev[p] = px_a[p];
        capture_frame();
        check_val("f2_fs_period", 32'(fs_next), 32'd1);
        mism = 0;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
`ifdef PATGEN_SCROLL_EN
                if (px_a[(y+3)*20 + 6 + x] !== px_prev[(y+3)*20 + 6 + ((x+1) % 8)]) mism++;
`else
                if (px_a[(y+3)*20 + 6 + x] !== px_prev[(y+3)*20 + 6 + x]) mism++;
`endif
            end
        check_val("f2_vs_f1_bars", 32'(mism), 32'd0);
        key[3:1] = 3'b000;

        // Short glitch: too brief to count as a press
        advance(20);
        key[0] = 1'b1;
        advance(3);
        key[0] = 1'b0;
        advance(20);
        wait_fs("glitch", prev_sel);
        check_val("glitch_pt_sel", 32'(pt_sel), 32'd0);

        // Real press mid-frame: takes effect only at the next frame start
        advance(30);
        press_key();
        check_val("press_hold_mid", 32'(pt_sel), 32'd0);
        wait_fs("press1", prev_sel);
        check_val("press1_before", 32'(prev_sel), 32'd0);
        check_val("press1_after",  32'(pt_sel),   32'd1);
        capture_frame();
        check_line("ramp", 0, ramp_exp);
        check_line("ramp", 3, ramp_exp);

        // Three presses in one frame: 1 -> 0 through the mod-4 wrap
        advance(10);
        press_key();
        press_key();
        press_key();
        wait_fs("wrap", prev_sel);
        check_val("wrap_before", 32'(prev_sel), 32'd1);
        check_val("wrap_after",  32'(pt_sel),   32'd0);

        // Two presses in one frame: 0 -> 2 in a single step
        advance(10);
        press_key();
        press_key();
        wait_fs("two", prev_sel);
        check_val("two_before", 32'(prev_sel), 32'd0);
        check_val("two_after",  32'(pt_sel),   32'd2);
        capture_frame();
        check_line("solid", 0, solid_exp);
        check_line("solid", 2, solid_exp);

        advance(10);
        press_key();
        wait_fs("chk", prev_sel);
        check_val("chk_after", 32'(pt_sel), 32'd3);
        capture_frame();
`ifndef PATGEN_SCROLL_EN
        check_line("chk", 0, chk_a_exp);
        check_line("chk", 2, chk_b_exp);
`endif

        // Mid-frame reset while a pixel is being driven
        advance(88);
        check_val("pre_rst_dval", 32'(dval), 32'd1);
        rstn = 1'b0;
        tick();
        check_zero("mid_rst");
        release_check("mid_rel");
        wait_fs("post_rst", prev_sel);
        check_val("post_rst_pt_sel", 32'(pt_sel), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
